// File: rtl/dma_pkg.sv
// Shared types for the DMA read channel.
// Default widths match a CCI-P cache-line address and a 512-bit line.
package dma_pkg;

  localparam int CL_ADDR_W = 42;
  localparam int CL_DATA_W = 512;
  localparam int RSP_DEPTH = 512;

  typedef logic [CL_ADDR_W-1:0] cl_addr_t;
  typedef logic [CL_ADDR_W:0]   count_t;
  typedef logic [CL_DATA_W-1:0] cl_data_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } rd_state_t;

endpackage

// File: rtl/dma_fifo.sv
// First-word-fall-through FIFO for read responses.
// Head is always visible on rd_data; a pop while empty is dropped.
module dma_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + ONE_C;
        2'b01:   cnt <= cnt - ONE_C;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dma_rd_engine.sv
// DMA read channel: one request per cache line, credit-limited so the
// response FIFO never overflows, FWFT handshake toward the AFU.
module dma_rd_engine
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = CL_ADDR_W,
  parameter int DATA_WIDTH = CL_DATA_W,
  parameter int FIFO_DEPTH = RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH:0]   rd_size,
  input  logic                  rd_go,
  input  logic                  rd_en,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_almost_full,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  rd_state_t             state_q;
  rd_state_t             state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   size_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH:0]   popped_q;
  logic [CW-1:0]         credits_q;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  issue;
  logic                  pop;
  logic                  start;

  assign start = rd_go && (state_q == S_IDLE || state_q == S_DONE);
  assign pop   = rd_en && !fifo_empty;
  assign issue = (state_q == S_ISSUE)
              && !mem_req_almost_full
              && (credits_q != '0)
              && (issued_q != size_q);

  assign mem_req_valid = issue;
  assign mem_req_addr  = issue ? base_q + issued_q[ADDR_WIDTH-1:0] : '0;
  assign rd_done       = (state_q == S_DONE);
  assign empty         = fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (rd_go) state_d = (rd_size == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (issue && (issued_q + CNT_ONE == size_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (popped_q + CNT_ONE == size_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      size_q    <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      credits_q <= CRED_MAX;
    end else begin
      state_q <= state_d;
      if (start) begin
        base_q   <= rd_addr;
        size_q   <= rd_size;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) issued_q <= issued_q + CNT_ONE;
        if (pop)   popped_q <= popped_q + CNT_ONE;
      end
      unique case ({issue, pop})
        2'b10:   credits_q <= credits_q - CRED_ONE;
        2'b01:   credits_q <= credits_q + CRED_ONE;
        default: credits_q <= credits_q;
      endcase
    end
  end

  // Responses beyond the credit window mean the shim broke the protocol.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_rsp_valid && fifo_full && !pop));
      assert (32'(credits_q) + 32'(fifo_count) <= FIFO_DEPTH);
    end
  end

  dma_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_rsp_valid),
    .wr_data (mem_rsp_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed bench for dma_rd_engine with an in-order one-cycle shim model.
// Response data is a fixed function of the requested address.
module tb_dma_rd_engine;

  localparam int AW = 42;
  localparam int DW = 32;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_size;
  logic          rd_go;
  logic          rd_en;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          rd_done;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_almost_full;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [63:0] req_log [$];
  logic [63:0] pop_log [$];
  logic [AW-1:0] shim_q [$];

  always #5 clk = ~clk;

  dma_rd_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rd_addr             (rd_addr),
    .rd_size             (rd_size),
    .rd_go               (rd_go),
    .rd_en               (rd_en),
    .empty               (empty),
    .rd_data             (rd_data),
    .rd_done             (rd_done),
    .mem_req_valid       (mem_req_valid),
    .mem_req_addr        (mem_req_addr),
    .mem_req_almost_full (mem_req_almost_full),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data)
  );

  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    return a[31:0] ^ 32'h5EED_0000;
  endfunction

  // Shim and monitor, both at mid-cycle when DUT outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      shim_q.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end else begin
      if (shim_q.size() > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_data(shim_q.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
      end
      if (mem_req_valid) begin
        shim_q.push_back(mem_req_addr);
        req_log.push_back(64'(mem_req_addr));
      end
      if (rd_en && !empty) pop_log.push_back(64'(rd_data));
      if (mem_req_almost_full && mem_req_valid) viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reqs(input string tag, input logic [AW-1:0] base,
                          input int n);
    logic [AW-1:0] a;
    chk({tag, "_nreq"}, 64'(req_log.size()), 64'(n));
    for (int i = 0; i < n && i < req_log.size(); i++) begin
      a = base + AW'(i);
      chk($sformatf("%s_req%0d", tag, i), req_log[i], 64'(a));
    end
  endtask

  task automatic chk_pops(input string tag, input logic [AW-1:0] base,
                          input int n);
    logic [AW-1:0] a;
    chk({tag, "_npop"}, 64'(pop_log.size()), 64'(n));
    for (int i = 0; i < n && i < pop_log.size(); i++) begin
      a = base + AW'(i);
      chk($sformatf("%s_pop%0d", tag, i), pop_log[i], 64'(line_data(a)));
    end
  endtask

  task automatic go(input logic [AW-1:0] a, input logic [AW:0] s);
    rd_addr = a;
    rd_size = s;
    rd_go   = 1'b1;
    tick();
    rd_go   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!rd_done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(rd_done), 64'd1);
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    rd_size = '0;
    rd_go = 1'b0;
    rd_en = 1'b0;
    mem_req_almost_full = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_done", 64'(rd_done), 64'd0);
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'd0);

    // Basic: 4 lines from 0x100, AFU always popping
    clear_logs();
    rd_en = 1'b1;
    go(42'h100, 43'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_v%0d", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("basic_a%0d", i), 64'(mem_req_addr), 64'h100 + 64'(i));
      tick();
    end
    chk("basic_drain_v", 64'(mem_req_valid), 64'd0);
    tick();
    chk("basic_done_c6", 64'(rd_done), 64'd0);
    tick();
    chk("basic_done_c7", 64'(rd_done), 64'd1);
    chk("basic_empty", 64'(empty), 64'd1);
    chk_pops("basic", 42'h100, 4);

    // Zero size
    clear_logs();
    go(42'h700, 43'd0);
    chk("zero_done", 64'(rd_done), 64'd1);
    chk("zero_valid", 64'(mem_req_valid), 64'd0);
    repeat (5) tick();
    chk("zero_nreq", 64'(req_log.size()), 64'd0);
    chk("zero_empty", 64'(empty), 64'd1);

    // Credit stall: nothing popped, only FIFO_DEPTH requests go out
    clear_logs();
    rd_en = 1'b0;
    go(42'h2000, 43'd20);
    repeat (30) tick();
    chk("stall_nreq8", 64'(req_log.size()), 64'd8);
    chk("stall_valid", 64'(mem_req_valid), 64'd0);
    chk("stall_empty", 64'(empty), 64'd0);
    rd_en = 1'b1;
    tick();
    tick();
    tick();
    rd_en = 1'b0;
    repeat (20) tick();
    chk("stall_nreq11", 64'(req_log.size()), 64'd11);
    chk("stall_npop3", 64'(pop_log.size()), 64'd3);
    rd_en = 1'b1;
    wait_done("stall", 200);
    chk_reqs("stall", 42'h2000, 20);
    chk_pops("stall", 42'h2000, 20);

    // Back-pressure toggling every cycle
    clear_logs();
    viol = 0;
    go(42'h300, 43'd16);
    for (int n = 0; n < 300 && !rd_done; n++) begin
      mem_req_almost_full = ~mem_req_almost_full;
      tick();
    end
    mem_req_almost_full = 1'b0;
    chk("bp_done", 64'(rd_done), 64'd1);
    chk("bp_viol", 64'(viol), 64'd0);
    chk_reqs("bp", 42'h300, 16);
    chk_pops("bp", 42'h300, 16);

    // Address wrap, rd_en held high across empty cycles
    clear_logs();
    go(42'h3FF_FFFF_FFFE, 43'd4);
    wait_done("wrap", 100);
    repeat (4) tick();
    chk("wrap_a2", req_log.size() > 2 ? req_log[2] : 64'hDEAD, 64'd0);
    chk("wrap_a3", req_log.size() > 3 ? req_log[3] : 64'hDEAD, 64'd1);
    chk_reqs("wrap", 42'h3FF_FFFF_FFFE, 4);
    chk_pops("wrap", 42'h3FF_FFFF_FFFE, 4);
    chk("wrap_empty", 64'(empty), 64'd1);

    // Second go while issuing is ignored
    clear_logs();
    go(42'h400, 43'd6);
    tick();
    go(42'h900, 43'd2);
    wait_done("busy", 100);
    chk_reqs("busy", 42'h400, 6);
    chk_pops("busy", 42'h400, 6);

    // Reset while draining, then a fresh transfer
    clear_logs();
    rd_en = 1'b0;
    go(42'h500, 43'd4);
    repeat (7) tick();
    chk("rstd_valid", 64'(mem_req_valid), 64'd0);
    chk("rstd_full", 64'(empty), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstd_empty", 64'(empty), 64'd1);
    chk("rstd_done", 64'(rd_done), 64'd0);
    tick();
    chk("rstd_idle_v", 64'(mem_req_valid), 64'd0);
    clear_logs();
    rd_en = 1'b1;
    go(42'h600, 43'd2);
    wait_done("fresh", 50);
    chk_reqs("fresh", 42'h600, 2);
    chk_pops("fresh", 42'h600, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
